// File: rtl/aipp_power_gate_sequencer.sv
// ALU power-gate sequencer: arbitrates N command-processor requesters and walks each
// token-backed grant through ramp, leased dispatch, drain and a guard off-time.
module aipp_power_gate_sequencer #(
    parameter int N_REQ        = 4,
    parameter int RAMP_CYCLES  = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int GUARD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tok_load,
    input  logic [127:0]      tok_data,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  grant,
    output logic              alu_power_enable,
    output logic              dispatch_ready,
    output logic              tok_avail,
    output logic              lease_expired,
    output logic              busy
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAX_RD = (RAMP_CYCLES > DRAIN_CYCLES) ? RAMP_CYCLES : DRAIN_CYCLES;
    localparam int MAX_PH = (MAX_RD > GUARD_CYCLES) ? MAX_RD : GUARD_CYCLES;
    localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

    localparam logic [PH_W-1:0]  RAMP_LAST  = PH_W'(RAMP_CYCLES - 1);
    localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);
    localparam logic [PH_W-1:0]  GUARD_LAST = PH_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("aipp_power_gate_sequencer: N_REQ must be 2..8");
    end
    if (RAMP_CYCLES < 1 || DRAIN_CYCLES < 1 || GUARD_CYCLES < 1) begin : g_bad_phase
        $error("aipp_power_gate_sequencer: phase lengths must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RAMP   = 3'd1,
        ACTIVE = 3'd2,
        DRAIN  = 3'd3,
        GUARD  = 3'd4
    } state_t;

    state_t            state;
    logic [15:0]       tok_lease;
    logic [15:0]       lease_cnt;
    logic [PH_W-1:0]   phase_cnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  rr_next;
    logic              tok_ok;
    logic              owner_req;
    logic              owner_done;
    logic              grant_fire;
    logic              unused_tok_hi;

    // Round-robin search: first set bit at or above ptr, wrapping past N_REQ-1.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                     input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] w;
        logic             found;
        w     = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign unused_tok_hi = ^tok_data[127:80];
    assign tok_ok        = tok_load && (tok_data[63:0] != 64'd0) && (tok_data[79:64] != 16'd0);
    assign owner_req     = |(req & grant);
    assign owner_done    = |(done & grant);
    assign grant_fire    = (state == IDLE) && (|req) && tok_avail;
    assign winner        = pick_winner(req, rr_ptr);
    assign rr_next       = (winner == LAST_IDX) ? '0 : winner + 1'b1;
    assign busy          = (state != IDLE);

    // A coincident valid load wins over consumption, so the fresh token survives a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_avail <= 1'b0;
            tok_lease <= 16'd0;
        end else if (tok_ok) begin
            tok_avail <= 1'b1;
            tok_lease <= tok_data[79:64];
        end else if (grant_fire) begin
            tok_avail <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            grant            <= '0;
            alu_power_enable <= 1'b0;
            dispatch_ready   <= 1'b0;
            lease_expired    <= 1'b0;
            lease_cnt        <= 16'd0;
            phase_cnt        <= '0;
            rr_ptr           <= '0;
        end else begin
            lease_expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        grant            <= N_REQ'(1) << winner;
                        alu_power_enable <= 1'b1;
                        lease_cnt        <= tok_lease;
                        rr_ptr           <= rr_next;
                        phase_cnt        <= '0;
                        state            <= RAMP;
                    end
                end
                RAMP: begin
                    if (!owner_req) begin
                        phase_cnt <= '0;
                        state     <= DRAIN;
                    end else if (phase_cnt == RAMP_LAST) begin
                        phase_cnt      <= '0;
                        dispatch_ready <= 1'b1;
                        state          <= ACTIVE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    // Owner completion or withdrawal takes priority over the expiry pulse.
                    lease_cnt <= lease_cnt - 16'd1;
                    if (owner_done || !owner_req) begin
                        dispatch_ready <= 1'b0;
                        phase_cnt      <= '0;
                        state          <= DRAIN;
                    end else if (lease_cnt == 16'd1) begin
                        dispatch_ready <= 1'b0;
                        lease_expired  <= 1'b1;
                        phase_cnt      <= '0;
                        state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (phase_cnt == DRAIN_LAST) begin
                        alu_power_enable <= 1'b0;
                        grant            <= '0;
                        phase_cnt        <= '0;
                        state            <= GUARD;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (phase_cnt == GUARD_LAST) begin
                        phase_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_ready_needs_power: assert property (@(posedge clk) disable iff (!rst_n)
        dispatch_ready |-> (alu_power_enable && $onehot(grant)));
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));
    a_power_needs_owner: assert property (@(posedge clk) disable iff (!rst_n)
        alu_power_enable |-> (grant != '0));

endmodule

// File: tb/tb_aipp_power_gate_sequencer.sv
// Scoreboard bench: expected grant owners and dispatch windows are queued as stimulus
// is applied and retired by a negedge monitor as the sequencer walks each grant.
module tb_aipp_power_gate_sequencer;

    localparam int N_REQ = 4;
    localparam int RAMP  = 4;
    localparam int DRAIN = 2;
    localparam int GUARD = 3;

    logic              clk;
    logic              rst_n;
    logic              tok_load;
    logic [127:0]      tok_data;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  done;
    logic [N_REQ-1:0]  grant;
    logic              alu_power_enable;
    logic              dispatch_ready;
    logic              tok_avail;
    logic              lease_expired;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    logic [N_REQ-1:0] grant_q[$];
    int               dr_q[$];
    logic             le_q[$];

    aipp_power_gate_sequencer #(
        .N_REQ(N_REQ), .RAMP_CYCLES(RAMP), .DRAIN_CYCLES(DRAIN), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tok_load(tok_load), .tok_data(tok_data),
        .req(req), .done(done), .grant(grant), .alu_power_enable(alu_power_enable),
        .dispatch_ready(dispatch_ready), .tok_avail(tok_avail),
        .lease_expired(lease_expired), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_tok(input logic [63:0] id, input logic [15:0] lease);
        @(negedge clk);
        tok_data = {48'h0, lease, id};
        tok_load = 1'b1;
        @(negedge clk);
        tok_load = 1'b0;
        tok_data = '0;
    endtask

    // sel: 0 = alu_power_enable, 1 = dispatch_ready, 2 = busy
    task automatic wait_sig(input int sel, input logic val, input string tag);
        logic cur;
        cur = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cur = (sel == 0) ? alu_power_enable : (sel == 1) ? dispatch_ready : busy;
            if (cur == val) return;
        end
        chk({tag, "_timeout"}, {31'b0, cur}, {31'b0, val});
    endtask

    task automatic expect_grant(input logic [N_REQ-1:0] g, input int dr_len, input logic le);
        grant_q.push_back(g);
        dr_q.push_back(dr_len);
        le_q.push_back(le);
    endtask

    // Monitor: tracks each grant through its phases and retires scoreboard entries.
    int mon_ph = 0;
    int mon_cnt = 0;
    initial begin
        logic [N_REQ-1:0] exp_g;
        int               exp_dr;
        logic             exp_le;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_ph = 0;
            end else begin
                case (mon_ph)
                    0: if (grant != '0) begin
                        exp_g = (grant_q.size() > 0) ? grant_q.pop_front() : '0;
                        chk("grant_owner", {28'b0, grant}, {28'b0, exp_g});
                        chk("power_at_grant", {31'b0, alu_power_enable}, 32'd1);
                        mon_ph = 1;
                        mon_cnt = 1;
                    end
                    1: if (dispatch_ready) begin
                        chk("ramp_len", mon_cnt, RAMP);
                        mon_ph = 2;
                        mon_cnt = 1;
                    end else begin
                        mon_cnt++;
                    end
                    2: if (dispatch_ready) begin
                        mon_cnt++;
                    end else begin
                        exp_dr = (dr_q.size() > 0) ? dr_q.pop_front() : -1;
                        exp_le = (le_q.size() > 0) ? le_q.pop_front() : 1'b0;
                        chk("ready_len", mon_cnt, exp_dr);
                        chk("lease_expired", {31'b0, lease_expired}, {31'b0, exp_le});
                        mon_ph = 3;
                        mon_cnt = 1;
                    end
                    3: if (alu_power_enable) begin
                        if (mon_cnt == 1) chk("lease_exp_width", {31'b0, lease_expired}, 32'd0);
                        mon_cnt++;
                    end else begin
                        chk("drain_len", mon_cnt, DRAIN);
                        chk("grant_off", {28'b0, grant}, 32'd0);
                        mon_ph = 4;
                        mon_cnt = 1;
                    end
                    4: if (busy) begin
                        mon_cnt++;
                    end else begin
                        chk("guard_len", mon_cnt, GUARD);
                        mon_ph = 0;
                    end
                    default: mon_ph = 0;
                endcase
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        tok_load = 1'b0;
        tok_data = '0;
        req      = '0;
        done     = '0;
        #1;
        chk("rst_grant", {28'b0, grant}, 32'd0);
        chk("rst_power", {31'b0, alu_power_enable}, 32'd0);
        chk("rst_ready", {31'b0, dispatch_ready}, 32'd0);
        chk("rst_tok", {31'b0, tok_avail}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // No token, then two invalid tokens: requests must never be served.
        req = 4'b1111;
        repeat (6) begin
            @(negedge clk);
            chk("notok_idle", {26'b0, grant, alu_power_enable, tok_avail}, 32'd0);
        end
        load_tok(64'd0, 16'd8);
        load_tok(64'h55, 16'd0);
        repeat (6) begin
            @(negedge clk);
            chk("badtok_idle", {26'b0, grant, alu_power_enable, tok_avail}, 32'd0);
        end
        req = '0;
        @(negedge clk);

        // Basic grant: lease 10 runs to expiry.
        expect_grant(4'b0001, 10, 1'b1);
        req = 4'b0001;
        load_tok(64'h1234, 16'd10);
        wait_sig(0, 1'b1, "basic_power");
        chk("tok_consumed", {31'b0, tok_avail}, 32'd0);
        wait_sig(2, 1'b0, "basic_idle");
        req = '0;

        // Early done on ACTIVE cycle 3.
        expect_grant(4'b0001, 3, 1'b0);
        req = 4'b0001;
        load_tok(64'h2, 16'd10);
        wait_sig(1, 1'b1, "early_ready");
        repeat (2) @(negedge clk);
        done = 4'b0001;
        @(negedge clk);
        done = '0;
        wait_sig(2, 1'b0, "early_idle");

        // Done on the final lease cycle suppresses the expiry pulse.
        expect_grant(4'b0001, 4, 1'b0);
        load_tok(64'h3, 16'd4);
        wait_sig(1, 1'b1, "last_ready");
        repeat (3) @(negedge clk);
        done = 4'b0001;
        @(negedge clk);
        done = '0;
        wait_sig(2, 1'b0, "last_idle");

        // Token loaded during ACTIVE is held and drives the next grant's lease.
        expect_grant(4'b0001, 6, 1'b1);
        expect_grant(4'b0001, 5, 1'b1);
        load_tok(64'h4, 16'd6);
        wait_sig(1, 1'b1, "tact_ready");
        load_tok(64'h5, 16'd5);
        chk("tok_during_active", {31'b0, tok_avail}, 32'd1);
        wait_sig(2, 1'b0, "tact_idle1");
        chk("tok_after_guard", {31'b0, tok_avail}, 32'd1);
        wait_sig(0, 1'b1, "tact_power2");
        chk("tok_used_again", {31'b0, tok_avail}, 32'd0);
        wait_sig(2, 1'b0, "tact_idle2");
        req = '0;

        // Asynchronous reset mid-ACTIVE with a fresh token pending.
        grant_q.push_back(4'b0001);
        req = 4'b0001;
        load_tok(64'h6, 16'd20);
        wait_sig(1, 1'b1, "rst_ready_wait");
        load_tok(64'h7, 16'd7);
        chk("rst_tok_pending", {31'b0, tok_avail}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", {28'b0, grant}, 32'd0);
        chk("arst_power", {31'b0, alu_power_enable}, 32'd0);
        chk("arst_ready", {31'b0, dispatch_ready}, 32'd0);
        chk("arst_tok", {31'b0, tok_avail}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_nogrant", {27'b0, grant, alu_power_enable}, 32'd0);
        end
        req = '0;
        @(negedge clk);

        // Round-robin from a freshly reset pointer, one token per grant.
        expect_grant(4'b0001, 2, 1'b1);
        expect_grant(4'b0010, 2, 1'b1);
        expect_grant(4'b0100, 2, 1'b1);
        expect_grant(4'b1000, 2, 1'b1);
        expect_grant(4'b0001, 2, 1'b1);
        req = 4'b1111;
        load_tok(64'h10, 16'd2);
        for (int k = 0; k < 5; k++) begin
            wait_sig(0, 1'b1, "rr_power_on");
            wait_sig(0, 1'b0, "rr_power_off");
            if (k < 4) load_tok(64'h11 + 64'(k), 16'd2);
        end
        wait_sig(2, 1'b0, "rr_idle");
        repeat (4) @(negedge clk);
        chk("rr_no_extra", {27'b0, grant, alu_power_enable}, 32'd0);
        req = '0;

        chk("grant_q_drained", grant_q.size(), 32'd0);
        chk("ready_q_drained", dr_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
